// File: rtl/add8_sad_sequencer.sv
// add8_sad_sequencer
// Drives the shared ADD_8 adder tree with packed abs-diff rows, accumulates
// one SAD per candidate block and keeps the smallest SAD (earliest index on
// ties). The final minimum is offered on a valid/ready result port.
module add8_sad_sequencer #(
    parameter int ELEMENT_BIT_DEPTH = 14,
    parameter int ROWS              = 8,
    parameter int NUM_CAND          = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic                                       row_valid,
    output logic                                       row_ready,
    input  logic [ELEMENT_BIT_DEPTH*8-1:0]             row_data,
    output logic [ELEMENT_BIT_DEPTH*8-1:0]             add8_addend_array,
    input  logic [ELEMENT_BIT_DEPTH-1:0]               add8_sum,
    output logic                                       res_valid,
    input  logic                                       res_ready,
    output logic [ELEMENT_BIT_DEPTH+$clog2(ROWS)-1:0]  res_sad,
    output logic [$clog2(NUM_CAND)-1:0]                res_idx,
    output logic                                       busy
);

    localparam int ROW_W  = $clog2(ROWS);
    localparam int CAND_W = $clog2(NUM_CAND);
    localparam int ACC_W  = ELEMENT_BIT_DEPTH + ROW_W;
    // Row counter needs at least one bit even when a block is a single row.
    localparam int CNT_W  = (ROW_W > 0) ? ROW_W : 1;

    localparam logic [CNT_W-1:0]  LAST_ROW  = CNT_W'(ROWS - 1);
    localparam logic [CAND_W-1:0] LAST_CAND = CAND_W'(NUM_CAND - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_r;
    logic [ACC_W-1:0]    acc_r;
    logic [CNT_W-1:0]    row_cnt_r;
    logic [CAND_W-1:0]   cand_cnt_r;
    logic [ACC_W-1:0]    best_sad_r;
    logic [CAND_W-1:0]   best_idx_r;

    logic                beat_s;
    logic [ACC_W-1:0]    cand_sad_s;
    logic                last_row_s;
    logic                last_cand_s;
    logic                better_s;
    logic [ACC_W-1:0]    min_sad_s;
    logic [CAND_W-1:0]   min_idx_s;

    // The adder tree sees the upstream row directly; no staging register.
    assign add8_addend_array = row_data;

    // Beat detection, running candidate SAD and minimum selection (strict < keeps earlier index on ties).
    always_comb begin
        beat_s      = row_valid && row_ready;
        cand_sad_s  = acc_r + ACC_W'(add8_sum);
        last_row_s  = (row_cnt_r == LAST_ROW);
        last_cand_s = (cand_cnt_r == LAST_CAND);
        better_s    = (cand_sad_s < best_sad_r);
        if (better_s) begin
            min_sad_s = cand_sad_s;
            min_idx_s = cand_cnt_r;
        end else begin
            min_sad_s = best_sad_r;
            min_idx_s = best_idx_r;
        end
    end

    // Search FSM with accumulators and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            acc_r      <= {ACC_W{1'b0}};
            row_cnt_r  <= {CNT_W{1'b0}};
            cand_cnt_r <= {CAND_W{1'b0}};
            best_sad_r <= {ACC_W{1'b0}};
            best_idx_r <= {CAND_W{1'b0}};
            res_sad    <= {ACC_W{1'b0}};
            res_idx    <= {CAND_W{1'b0}};
            row_ready  <= 1'b0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_ACCUM;
                        acc_r      <= {ACC_W{1'b0}};
                        row_cnt_r  <= {CNT_W{1'b0}};
                        cand_cnt_r <= {CAND_W{1'b0}};
                        best_sad_r <= {ACC_W{1'b1}};
                        best_idx_r <= {CAND_W{1'b0}};
                        row_ready  <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (beat_s) begin
                        if (last_row_s) begin
                            acc_r      <= {ACC_W{1'b0}};
                            row_cnt_r  <= {CNT_W{1'b0}};
                            best_sad_r <= min_sad_s;
                            best_idx_r <= min_idx_s;
                            if (last_cand_s) begin
                                // Result is published together with the final comparison.
                                state_r   <= ST_DONE;
                                res_sad   <= min_sad_s;
                                res_idx   <= min_idx_s;
                                row_ready <= 1'b0;
                                res_valid <= 1'b1;
                            end else begin
                                cand_cnt_r <= cand_cnt_r + CAND_W'(1);
                            end
                        end else begin
                            acc_r     <= cand_sad_s;
                            row_cnt_r <= row_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // res_valid is high throughout DONE, so res_ready alone completes the handshake.
                    if (res_ready) begin
                        state_r   <= ST_IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    row_ready <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add8_sad_sequencer.sv
// Directed bench for add8_sad_sequencer with a behavioural ADD_8 model.
module tb_add8_sad_sequencer;

    localparam int EBD = 14;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             row_valid;
    logic             row_ready;
    logic [EBD*8-1:0] row_data;
    logic [EBD*8-1:0] add8_addend_array;
    logic [EBD-1:0]   add8_sum;
    logic             res_valid;
    logic             res_ready;
    logic [16:0]      res_sad;
    logic [1:0]       res_idx;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    add8_sad_sequencer #(.ELEMENT_BIT_DEPTH(14), .ROWS(8), .NUM_CAND(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .add8_addend_array(add8_addend_array), .add8_sum(add8_sum),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sad(res_sad), .res_idx(res_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External ADD_8: sum of the eight addends, truncated to element width.
    always_comb begin
        add8_sum = 14'd0;
        for (int k = 0; k < 8; k++) add8_sum = add8_sum + add8_addend_array[k*EBD +: EBD];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one row and hold it until it is accepted; optional idle cycle afterwards.
    task automatic push_row(input logic [EBD*8-1:0] d, input bit gap);
        int n;
        row_data  = d;
        row_valid = 1'b1;
        n = 0;
        while (!row_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("row_ready_timeout", 32'd0, 32'd1);
        tick();
        row_valid = 1'b0;
        start     = 1'b0;
        if (gap) tick();
    endtask

    task automatic push_cand(input logic [EBD*8-1:0] d, input bit gap);
        for (int r = 0; r < 8; r++) push_row(d, gap);
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!res_valid && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("res_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic take_res(input string tag, input logic [16:0] exp_sad, input logic [1:0] exp_idx);
        wait_res();
        chk({tag, "_sad"}, 32'(res_sad), 32'(exp_sad));
        chk({tag, "_idx"}, 32'(res_idx), 32'(exp_idx));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_rowrdy"}, 32'(row_ready), 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    logic [EBD*8-1:0] row_ones, row_twos, row_mix, row_zero, row_big;
    int c0;

    initial begin
        row_ones  = {8{14'h0001}};
        row_twos  = {8{14'h0002}};
        row_zero  = {8{14'h0000}};
        row_big   = {8{14'h07ff}};
        row_mix   = {14'h02d8, 14'h0286, 14'h034d, 14'h0668,
                     14'h0575, 14'h07b9, 14'h0182, 14'h0769};
        rst_n     = 1'b0;
        start     = 1'b0;
        row_valid = 1'b0;
        row_data  = row_zero;
        res_ready = 1'b0;

        // Reset state
        tick();
        chk("rst_row_ready", 32'(row_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_sad", 32'(res_sad), 32'd0);
        chk("rst_res_idx", 32'(res_idx), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Uniform rows, continuous flow: tie rule and minimum latency
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        chk("uni_busy", 32'(busy), 32'd1);
        chk("uni_row_ready", 32'(row_ready), 32'd1);
        row_data = row_ones;
        #1;
        chk("passthru", 32'(add8_addend_array[31:0]), 32'(row_ones[31:0]));
        chk("add8_model", 32'(add8_sum), 32'd8);
        for (int c = 0; c < 4; c++) push_cand(row_ones, 1'b0);
        chk("uni_latency", 32'(cyc - c0), 32'd33);
        take_res("uni", 17'd64, 2'd0);
        chk("idle_hold_sad", 32'(res_sad), 32'd64);
        tick();
        chk("idle_no_rowrdy", 32'(row_ready), 32'd0);

        // Min pick with toggled row_valid, start pulses in ACCUM and DONE, held res_ready
        start = 1'b1;
        tick();
        start = 1'b0;
        push_cand(row_mix, 1'b1);
        start = 1'b1;                       // ignored: in ACCUM
        push_cand(row_mix, 1'b1);
        push_cand(row_zero, 1'b1);
        push_cand(row_mix, 1'b1);
        wait_res();
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);               // ignored: in DONE
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_sad", 32'(res_sad), 32'd0);
            chk("bp_idx", 32'(res_idx), 32'd2);
            tick();
        end
        start     = 1'b1;                   // ignored: DONE->IDLE cycle
        res_ready = 1'b1;
        tick();
        start     = 1'b0;
        res_ready = 1'b0;
        chk("mp_valid_drop", 32'(res_valid), 32'd0);
        chk("mp_busy_after", 32'(busy), 32'd0);
        tick();
        chk("mp_no_restart", 32'(busy), 32'd0);
        chk("mp_idle_hold", 32'(res_idx), 32'd2);

        // Minimum on candidate 0; exercises cand 0 SAD 0x12960
        start = 1'b1;
        tick();
        start = 1'b0;
        push_cand(row_mix, 1'b0);
        for (int c = 0; c < 3; c++) push_cand(row_big, 1'b0);
        take_res("min0", 17'h12960, 2'd0);

        // Back-to-back: new search right after handshake must reset best_sad
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        push_cand(row_twos, 1'b0);
        push_cand(row_ones, 1'b0);
        push_cand(row_twos, 1'b0);
        push_cand(row_ones, 1'b0);
        take_res("b2b", 17'd64, 2'd1);

        // Asynchronous reset in the middle of a search
        start = 1'b1;
        tick();
        start = 1'b0;
        push_cand(row_ones, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid_row_ready", 32'(row_ready), 32'd0);
        chk("amid_res_valid", 32'(res_valid), 32'd0);
        chk("amid_busy", 32'(busy), 32'd0);
        chk("amid_res_sad", 32'(res_sad), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        row_data  = row_ones;
        row_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", 32'({busy, row_ready, res_valid}), 32'd0);
        end
        row_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
